// File: rtl/partoserial_tx.sv
// Parallel-to-serial transmit stage: payload FIFO feeding an LSB-first shifter,
// with IDLE commas filling empty slots and a forced comma run after reset.
module partoserial_tx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SYNC_BC    = 8,
   parameter logic [7:0]  IDLE_CODE  = 8'hBC
) (
   input  logic       clk_8f,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       frame_sync,
   output logic       tx_active
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned SYNC_W = $clog2(SYNC_BC + 1);
   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BC);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        sh_q, sh_d;
   logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
   logic              tx_active_q, tx_active_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];

   logic slot_end;
   logic in_sync;
   logic push;
   logic pop;

   assign ready_out  = (count_q < CNT_FULL);
   assign data_out   = sh_q[0];
   assign frame_sync = (bit_cnt_q == 3'd0);
   assign tx_active  = tx_active_q;

   // Pop decisions see only the pre-edge count, so a byte pushed on the slot edge waits a slot.
   assign slot_end = (bit_cnt_q == 3'd7);
   assign in_sync  = (sync_cnt_q < SYNC_LAST);
   assign push     = valid_in && ready_out;
   assign pop      = slot_end && !in_sync && (count_q != '0);

   always_comb begin
      bit_cnt_d   = bit_cnt_q + 3'd1;
      sh_d        = {1'b0, sh_q[7:1]};
      sync_cnt_d  = sync_cnt_q;
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      mem_d       = mem_q;

      if (slot_end) begin
         if (in_sync) begin
            sh_d       = IDLE_CODE;
            sync_cnt_d = sync_cnt_q + SYNC_W'(1);
         end else if (pop) begin
            sh_d     = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            sh_d = IDLE_CODE;
         end
      end

      if (push) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      tx_active_d = tx_active_q || (sync_cnt_d == SYNC_LAST);
   end

   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         bit_cnt_q   <= '0;
         sh_q        <= IDLE_CODE;
         sync_cnt_q  <= SYNC_W'(1);
         tx_active_q <= (SYNC_BC == 1);
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         sync_cnt_q  <= sync_cnt_d;
         tx_active_q <= tx_active_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_partoserial_tx.sv
// Bench for partoserial_tx: a serial monitor rebuilds bytes from the line and
// matches payload against a queue of expected bytes and slot positions.
module tb_partoserial_tx;

   localparam logic [7:0] IDLE = 8'hBC;
   localparam int SYNC = 8;

   logic       clk_8f;
   logic       reset_L;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       data_out;
   logic       frame_sync;
   logic       tx_active;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_data_q [$];
   int         exp_slot_q [$];

   logic [2:0] tb_bit;
   int         mon_slot;
   logic [7:0] rx_sh;
   logic [7:0] ed;
   int         es;

   partoserial_tx dut (
      .clk_8f    (clk_8f),
      .reset_L   (reset_L),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .frame_sync(frame_sync),
      .tx_active (tx_active)
   );

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   // Independent bit position: the bit index present on the line between edges.
   always @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) tb_bit <= 3'd0;
      else          tb_bit <= tb_bit + 3'd1;
   end

   // Loopback receiver: rebuild each byte, check framing and payload order/slot.
   always @(negedge clk_8f) begin
      if (!reset_L) begin
         mon_slot = 0;
         rx_sh    = 8'h00;
      end else begin
         checks++;
         if (frame_sync !== (tb_bit == 3'd0)) begin
            errors++;
            $display("FAIL frame_sync: got %b expected %b at bit %0d", frame_sync, (tb_bit == 3'd0), tb_bit);
         end
         rx_sh = {data_out, rx_sh[7:1]};
         if (tb_bit == 3'd7) begin
            if (rx_sh !== IDLE) begin
               checks++;
               if (mon_slot < SYNC) begin
                  errors++;
                  $display("FAIL early_payload: got %h in slot %0d, required none before slot %0d", rx_sh, mon_slot, SYNC);
               end
               checks++;
               if (exp_data_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_byte: got %h in slot %0d, required IDLE", rx_sh, mon_slot);
               end else begin
                  ed = exp_data_q.pop_front();
                  es = exp_slot_q.pop_front();
                  if (rx_sh !== ed || (es >= 0 && mon_slot != es)) begin
                     errors++;
                     $display("FAIL payload: got %h in slot %0d, required %h in slot %0d", rx_sh, mon_slot, ed, es);
                  end
               end
            end
            mon_slot++;
         end
      end
   end

   task automatic step();
      @(posedge clk_8f);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input int slot, output int acc_bit);
      bit done = 1'b0;
      acc_bit  = -1;
      valid_in = 1'b1;
      data_in  = b;
      for (int i = 0; i < 64 && !done; i++) begin
         if (ready_out) begin
            acc_bit = int'(tb_bit);
            exp_data_q.push_back(b);
            exp_slot_q.push_back(slot);
            done = 1'b1;
         end
         step();
      end
      valid_in = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: byte %h not accepted, ready_out %b", b, ready_out);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_data_q.size() != 0 && n < 600) begin
         step();
         n++;
      end
      checks++;
      if (exp_data_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d bytes still pending, required 0", exp_data_q.size());
         exp_data_q.delete();
         exp_slot_q.delete();
      end
   endtask

   task automatic align(input logic [2:0] b);
      for (int i = 0; i < 8 && tb_bit != b; i++) step();
   endtask

   task automatic test_reset();
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;
      repeat (3) step();
      checks++;
      if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out: got %b required 0", data_out); end
      checks++;
      if (frame_sync !== 1'b1) begin errors++; $display("FAIL reset_frame_sync: got %b required 1", frame_sync); end
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_out); end
      checks++;
      if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active: got %b required 0", tx_active); end
      reset_L = 1'b1;
   endtask

   task automatic test_sync_run();
      logic [7:0] idle_v = IDLE;
      for (int n = 0; n <= 56; n++) begin
         if (n < 16) begin
            checks++;
            if (data_out !== idle_v[n % 8]) begin
               errors++;
               $display("FAIL comma_bit: cycle %0d got %b required %b", n, data_out, idle_v[n % 8]);
            end
         end
         if (n == 55 || n == 56) begin
            checks++;
            if (tx_active !== (n == 56)) begin
               errors++;
               $display("FAIL tx_active_rise: cycle %0d got %b required %b", n, tx_active, (n == 56));
            end
         end
         if (n < 56) step();
      end
   endtask

   task automatic test_first_payload();
      int ab;
      reset_L = 1'b0;
      repeat (2) step();
      reset_L = 1'b1;
      step();
      push_byte(8'hA5, SYNC, ab);
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL first_ready: got %b required 1", ready_out); end
      drain();
   endtask

   task automatic test_back_to_back();
      int ab;
      int cur;
      checks++;
      if (tx_active !== 1'b1) begin errors++; $display("FAIL active_before_b2b: got %b required 1", tx_active); end
      align(3'd0);
      cur = mon_slot;
      for (int i = 1; i <= 4; i++) push_byte(8'(i), cur + i, ab);
      checks++;
      if (ready_out !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", ready_out); end
      push_byte(8'h05, cur + 5, ab);
      checks++;
      if (ab != 0) begin errors++; $display("FAIL held_accept_bit: got %0d required 0", ab); end
      drain();
   endtask

   task automatic test_slot_edge_push();
      int ab;
      align(3'd7);
      push_byte(8'h3C, mon_slot + 2, ab);
      checks++;
      if (ab != 7) begin errors++; $display("FAIL edge_accept_bit: got %0d required 7", ab); end
      drain();
   endtask

   task automatic test_async_reset();
      int ab;
      align(3'd0);
      push_byte(8'h11, -1, ab);
      push_byte(8'h22, -1, ab);
      push_byte(8'h33, -1, ab);
      exp_data_q.delete();
      exp_slot_q.delete();
      checks++;
      if (frame_sync !== 1'b0 || data_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_line: frame_sync %b data_out %b, required 0 and 1", frame_sync, data_out);
      end
      reset_L = 1'b0;
      #1;
      checks++;
      if (data_out !== 1'b0) begin errors++; $display("FAIL async_data_out: got %b required 0", data_out); end
      checks++;
      if (frame_sync !== 1'b1) begin errors++; $display("FAIL async_frame_sync: got %b required 1", frame_sync); end
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL async_ready: got %b required 1", ready_out); end
      checks++;
      if (tx_active !== 1'b0) begin errors++; $display("FAIL async_tx_active: got %b required 0", tx_active); end
      repeat (2) step();
      reset_L = 1'b1;
      step();
      push_byte(8'h77, SYNC, ab);
      drain();
   endtask

   task automatic test_random_stream();
      int ab;
      logic [7:0] b;
      for (int i = 0; i < 20; i++) begin
         b = 8'($urandom_range(0, 255));
         while (b == IDLE) b = 8'($urandom_range(0, 255));
         push_byte(b, -1, ab);
         repeat ($urandom_range(0, 3)) step();
      end
      drain();
   endtask

   initial begin
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;
      test_reset();
      test_sync_run();
      test_first_payload();
      test_back_to_back();
      test_slot_edge_push();
      test_async_reset();
      test_random_stream();
      repeat (16) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
